// File: rtl/vga_pkg.sv
// Shared VGA constants and the VRAM arbiter state encoding.
package vga_pkg;

  localparam int H_ACTIVE     = 800;
  localparam int V_ACTIVE     = 600;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 12;
  localparam int FIFO_DEPTH   = 16;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DONE       = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead pixel FIFO; flush beats push and pop, dout reads 0 when empty.
module pixel_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between raster-order display prefetch and a pixel writer.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int ADDR_W     = vga_pkg::ADDR_W,
  parameter int DATA_W     = vga_pkg::DATA_W,
  parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              inflight_q, inflight_d;
  logic              underflow_q, underflow_d;
  logic [CW-1:0]     fifo_count, occ;
  logic              fifo_empty, fifo_full, fifo_push;
  logic              urgent, slot_free, rd_issue, wr_fire;

  // A read issued last cycle is counted as occupied so we never overfill.
  assign occ    = fifo_count + CW'(inflight_q);
  assign urgent = (state_q == ACTIVE) && (occ < CW'(FIFO_DEPTH / 2));

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_FRAME;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      underflow_q  <= underflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    slot_free    = 1'b0;
    rd_issue     = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (urgent) begin
          rd_issue = 1'b1;
        end else begin
          slot_free = 1'b1;
          if (!wr_valid && occ < CW'(FIFO_DEPTH)) rd_issue = 1'b1;
        end
      end
      default: slot_free = 1'b1;
    endcase
    if (rd_issue) begin
      fetch_addr_d = fetch_addr_q + 1'b1;
      if (fetch_addr_q == LAST_ADDR) state_d = DONE;
    end
    // A read issued alongside frame_start belongs to the old frame and is dropped.
    inflight_d  = rd_issue & ~frame_start;
    underflow_d = underflow_q | (pix_rd & fifo_empty);
    if (frame_start) begin
      state_d      = ACTIVE;
      fetch_addr_d = '0;
      underflow_d  = 1'b0;
    end
  end

  assign wr_ready = slot_free & ~rst;
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_fire) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_issue) begin
      mem_addr  = fetch_addr_q;
    end
  end

  assign fifo_push = inflight_q & ~fifo_full;

  pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MAX10_CLK1_50),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pix_rd),
    .flush (frame_start),
    .din   (mem_rdata),
    .dout  (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pix_valid = ~fifo_empty;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter against a queue-based model of the slot and prefetch rules.
module tb_vram_arbiter;

  localparam int HA    = 8;
  localparam int VA    = 4;
  localparam int FRAME = HA * VA;
  localparam int DEPTH = 16;
  localparam int AW    = 19;
  localparam int DW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_rd = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          pix_valid, underflow, wr_ready, mem_we;
  logic [DW-1:0] pix_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad   = 0;

  vram_arbiter #(
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .pix_rd        (pix_rd),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .underflow     (underflow),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initVal(int a);
    return DW'((a * 37 + 5) ^ (a >> 3));
  endfunction

  // The bench-side VRAM: one-cycle read latency, written on mem_we.
  logic [DW-1:0] envMem [int];
  always @(posedge clk) begin
    if (mem_we) envMem[int'(mem_addr)] = mem_wdata;
    else mem_rdata <= envMem.exists(int'(mem_addr)) ? envMem[int'(mem_addr)] : initVal(int'(mem_addr));
  end

  // Reference model: state as 0/1/2, the FIFO as a queue, VRAM as an associative array.
  int            ms;
  int            mfetch;
  logic [DW-1:0] mq [$];
  bit            minf;
  logic [DW-1:0] mflv;
  bit            munder;
  logic [DW-1:0] mvram [int];

  function automatic logic [DW-1:0] modelVal(int a);
    if (mvram.exists(a)) return mvram[a];
    return initVal(a);
  endfunction

  task automatic modelReset();
    ms = 0; mfetch = 0; mq.delete(); minf = 0; munder = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit fs, input bit prd, input bit wv,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int occ;
    bit urg, expReady, doRd, doWr;
    logic [DW-1:0] rv;
    @(negedge clk);
    rst = r; frame_start = fs; pix_rd = prd; wr_valid = wv; wr_addr = wa; wr_data = wd;
    if (r) modelReset();
    #1;
    occ      = mq.size() + int'(minf);
    urg      = (ms == 1) && (occ < DEPTH / 2);
    expReady = !r && (ms != 1 || !urg);
    doRd     = !r && (ms == 1) && (urg || (!wv && occ < DEPTH));
    doWr     = wv && expReady;
    checkOutput("wr_ready", 32'(wr_ready), 32'(expReady));
    checkOutput("mem_we", 32'(mem_we), 32'(doWr));
    if (doWr) begin
      checkOutput("wr_addr", 32'(mem_addr), 32'(wa));
      checkOutput("wr_data", 32'(mem_wdata), 32'(wd));
    end else if (doRd) begin
      checkOutput("rd_addr", 32'(mem_addr), 32'(mfetch));
    end else if (r) begin
      checkOutput("rst_addr", 32'(mem_addr), 32'h0);
      checkOutput("rst_wdata", 32'(mem_wdata), 32'h0);
    end
    checkOutput("pix_valid", 32'(pix_valid), 32'(mq.size() != 0));
    checkOutput("pix_data", 32'(pix_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    checkOutput("underflow", 32'(underflow), 32'(munder));
    @(posedge clk);
    if (r) return;
    rv = doRd ? modelVal(mfetch) : '0;
    if (doWr) mvram[int'(wa)] = wd;
    if (prd) begin
      if (mq.size() != 0) void'(mq.pop_front());
      else munder = 1;
    end
    if (minf) mq.push_back(mflv);
    minf = doRd;
    mflv = rv;
    if (doRd) begin
      if (mfetch == FRAME - 1) ms = 2;
      mfetch++;
    end
    if (fs) begin
      mq.delete(); minf = 0; mfetch = 0; ms = 1; munder = 0;
    end
  endtask

  task automatic idle(input int n, input bit prd, input bit wv);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, prd, wv, AW'($urandom_range(0, 40)), DW'($urandom));
  endtask

  initial begin
    modelReset();
    $display("[TB] reset values");
    repeat (3) applyStimulus(1, 0, 0, 1, AW'(5), DW'(7));

    $display("[TB] underflow before priming");
    idle(2, 0, 0);
    applyStimulus(0, 0, 1, 0, '0, '0);
    idle(4, 0, 0);

    $display("[TB] prime and saturate");
    applyStimulus(0, 1, 0, 0, '0, '0);
    idle(24, 0, 0);

    $display("[TB] writer versus display");
    for (int i = 0; i < 30; i++) begin
      if (i >= 10 && i < 13) applyStimulus(0, 0, 1, 1, AW'(19'h12345), DW'(12'hF00));
      else applyStimulus(0, 0, 1, 1, AW'($urandom_range(0, 40)), DW'($urandom));
    end

    $display("[TB] full frame fetch");
    applyStimulus(0, 1, 0, 0, '0, '0);
    idle(3, 0, 0);
    idle(50, 1, 0);
    idle(5, 0, 1);

    $display("[TB] frame_start with read in flight");
    applyStimulus(0, 1, 0, 0, '0, '0);
    applyStimulus(0, 1, 0, 0, '0, '0);
    idle(6, 0, 0);

    $display("[TB] reset in mid-frame");
    applyStimulus(0, 1, 0, 0, '0, '0);
    idle(12, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0);
    idle(5, 0, 0);

    $display("[TB] random traffic");
    applyStimulus(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 500; i++)
      applyStimulus(0, $urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
                    AW'($urandom_range(0, 40)), DW'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port synchronous frame-buffer RAM between the VGA scan-out path and a pixel writer (drawing engine or CPU). Sits between the 800x600 timing generator and the on-chip VRAM. It prefetches the active-area pixels of each frame, in raster order, into a small show-ahead FIFO. Writer accesses are granted in the slots the display does not urgently need.

## Interface
- H_ACTIVE, 800: active pixels per line
- V_ACTIVE, 600: active lines per frame
- ADDR_W, 19: VRAM address width; must satisfy H_ACTIVE*V_ACTIVE <= 2^ADDR_W
- DATA_W, 12: pixel width, 4:4:4 RGB
- FIFO_DEPTH, 16: prefetch FIFO entries; power of two, >= 4

Ports:
- MAX10_CLK1_50  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse from the timing generator, issued at least FIFO_DEPTH+2 cycles before the first active pixel
- pix_rd  in  1  pop the FIFO head; one pulse per active pixel
- pix_valid  out  1  FIFO not empty
- pix_data  out  DATA_W  FIFO head (show-ahead); 0 when empty
- underflow  out  1  sticky: pix_rd was seen while the FIFO was empty
- wr_valid  in  1  writer request
- wr_addr  in  ADDR_W  writer address
- wr_data  in  DATA_W  writer data
- wr_ready  out  1  writer slot granted this cycle
- mem_addr  out  ADDR_W  VRAM address
- mem_we  out  1  VRAM write enable
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid 1 cycle after the read address

## Operation
- FSM states:
  - WAIT_FRAME: reset state; no fetches.
  - ACTIVE: fetching the frame.
  - DONE: all H_ACTIVE*V_ACTIVE pixels fetched.
- FSM transitions:
  - frame_start moves any state to ACTIVE.
  - ACTIVE moves to DONE when the fetch address issued equals H_ACTIVE*V_ACTIVE-1.
- frame_start actions:
  - Flush the FIFO.
  - Reset fetch_addr to 0.
  - Mark any in-flight read as discarded, so the mem_rdata arriving next cycle is not pushed.
- Occupancy: occ = fifo_count + inflight, where inflight is 0 or 1.
- Urgent: ACTIVE and occ < FIFO_DEPTH/2.
- Per-cycle slot decision, exactly one of the following:
  - Urgent: issue a read at fetch_addr; wr_ready=0.
  - ACTIVE, not urgent, wr_valid=1: wr_ready=1; the write is performed.
  - ACTIVE, not urgent, wr_valid=0, occ < FIFO_DEPTH: issue a read.
  - WAIT_FRAME or DONE: wr_ready=1; no reads.
- wr_ready depends only on state and occ, never on wr_valid.
- A write transfer occurs when wr_valid and wr_ready are both high. It drives mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle.
- Read issue drives mem_we=0, mem_addr=fetch_addr, then increments fetch_addr. Without frame_start, fetch_addr never wraps.
- Push: the cycle after a non-discarded read, mem_rdata is written into the FIFO.
- Pop: pix_rd with pix_valid=1 removes the head.
  - pix_rd on empty: no pop, and underflow is set.
  - underflow clears only on frame_start or rst.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - frame_start with pix_rd: the flush wins and the pop is ignored.
  - frame_start with wr_valid: the write proceeds if wr_ready (state before the pulse) was 1.
- Writer address range is not checked. Writes to any address, including the region being fetched, are allowed. Ordering is by slot.

## Timing
- Output values while rst is asserted or just after reset:

| Output | Value |
|---|---|
| state | WAIT_FRAME |
| FIFO | empty |
| pix_valid | 0 |
| pix_data | 0 |
| underflow | 0 |
| mem_we | 0 |
| mem_addr | 0 |
| mem_wdata | 0 |
| wr_ready | 0 while rst high, then 1 in WAIT_FRAME |

- Read latency: read issued in cycle N → pushed at the end of N+1 → visible on pix_data in N+2 if the FIFO was empty.
- After frame_start in cycle F:
  - First read issues in F+1.
  - pix_valid rises in F+3.
  - FIFO reaches FIFO_DEPTH/2 by F+FIFO_DEPTH/2+2 (fetches are back-to-back while urgent).
- Worst-case display throughput is 1 pixel/cycle. Urgent fetches always win, so the FIFO cannot underflow unless pix_rd starts before the priming window.
- mem_* outputs are combinational from registered state plus the wr_* inputs. There is one write or one read per cycle, never both.

## Structure
- Shared package vga_pkg (existing timing constants live there):
  - H_ACTIVE, V_ACTIVE, FRAME_PIXELS, ADDR_W, DATA_W
  - arbiter state encoding (WAIT_FRAME=0, ACTIVE=1, DONE=2)
- Sub-module pixel_fifo: synchronous show-ahead FIFO with ports push, pop, flush, din, dout, count, empty, full. Its flush has priority over push and pop.
- The arbiter FSM, fetch counter, in-flight/discard flag and underflow flag are in vram_arbiter.

## Test plan
- Reset then frame_start with wr_valid=0 → reads at addresses 0,1,2,… from cycle F+1; pix_valid=1 at F+3; FIFO saturates at 16 with no reads while full.
- Continuous wr_valid, FIFO at 8 with pix_rd every cycle → reads win while occ<8 (wr_ready=0); writes are granted otherwise; a write to 0x12345 with data 0xF00 appears on mem_* in the grant cycle.
- Fetch the full frame (H_ACTIVE=4, V_ACTIVE=2 for speed) → last read at address 7; state DONE; wr_ready held at 1; no further reads.
- frame_start while a read is in flight → its mem_rdata is not pushed; FIFO empty at F+1; next read at address 0.
- pix_rd with FIFO empty (before priming) → pix_data=0; underflow=1 and stays high until the next frame_start.
- Assert rst mid-ACTIVE with FIFO at 10 → immediately pix_valid=0, mem_we=0, state WAIT_FRAME; no reads until frame_start.
